uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised asynchronous serial-to-parallel receiver. It is the next-generation serial receiver for the FPGA designs.
- Configurable data width, optional parity and one or two stop bits.
- Validates the start bit and reports framing and parity errors.
- Sits between the board RX pin and the byte-consuming logic (command parser, loopback TX).

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
UART_BPS, 9600, line baud rate
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY_EN, 0, 1 = parity bit present after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits, legal 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
rx  input  1  asynchronous serial line, idle high
po_data  output  DATA_BITS  received data, LSB = first bit on line
po_flag  output  1  one-cycle pulse: frame complete, po_data/error flags valid
frame_err  output  1  high with po_flag if any stop bit sampled low
parity_err  output  1  high with po_flag if parity mismatch (always 0 when PARITY_EN=0)
busy  output  1  high while FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-low.
- Reset values: all outputs 0; FSM IDLE; counters 0.
  - Synchroniser regs reset to 1 (line idle), so no spurious edge is seen after reset.
- Constants:
  - BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division).
  - HALF = BAUD_CNT_MAX/2 - 1.
  - Baud counter width = $clog2(BAUD_CNT_MAX).
- Input path: rx passes through 2 sync flops (s1, s2) plus a history flop s3.
  - Falling edge = s2==0 && s3==1; it is only honoured in IDLE.
  - All samples take s2.
- Baud counter:
  - Cleared to 0 on the cycle the edge is detected; counts 0..BAUD_CNT_MAX-1 and wraps while busy.
  - Held at 0 in IDLE.
  - Sample strobe = counter==HALF.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on falling edge; busy rises the next cycle.
  - START, on strobe:
    - s2==1 -> IDLE (false start/glitch; no po_flag, no error).
    - Otherwise -> DATA with bit_cnt=0.
  - DATA, on strobe: shift s2 in MSB-first into shift register (so the first received bit ends at LSB); bit_cnt+1.
    - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
  - PARITY, on strobe: parity_bad = (XOR of data bits ^ sampled bit ^ PARITY_ODD) != 0 -> STOP.
  - STOP, on strobe:
    - s2==0 sets a sticky stop_bad.
    - After STOP_BITS samples -> IDLE; baud counter cleared.
- Output stage: on the cycle after the final stop strobe:
  - po_flag=1 for exactly one cycle.
  - po_data loads the shift register.
  - frame_err=stop_bad; parity_err=parity_bad.
  - frame_err/parity_err are 0 whenever po_flag is 0.
  - po_data holds until the next completed frame; it is updated even when errors are flagged.
- Latency: the falling edge at s2 to po_flag is (1+DATA_BITS+PARITY_EN+STOP_BITS-1)*BAUD_CNT_MAX + HALF + 2 cycles. This counts from the edge-detect cycle.
- Back-to-back: returning to IDLE at mid-stop means a start edge arriving half a bit later is captured. The minimum-gap frame is received without loss.
- Break (line held low): one frame with frame_err=1. No further frames until the line returns high and falls again.
- Edge during busy: ignored.
- Reset mid-frame: immediate abort; no po_flag; next frame needs a fresh falling edge.
- Widths: bit_cnt 4 bits; shift register is DATA_BITS wide; parity is computed over DATA_BITS only.

Test Plan:
1. CLK_FREQ=160_000, UART_BPS=10_000 (BAUD_CNT_MAX=16), 8N1. Send 0xA5 -> single po_flag pulse; po_data=0xA5; frame_err=0; parity_err=0; busy low afterwards.
2. Same config, back-to-back 0x00, 0xFF, 0x3C with one stop bit and no idle gap -> three po_flag pulses in order with matching po_data; no errors.
3. Glitch: rx low for 5 cycles (< HALF) then high -> FSM returns to IDLE; no po_flag; busy pulses only while in START.
4. PARITY_EN=1, PARITY_ODD=0, DATA_BITS=7. Send 0x41 with parity bit 0 -> po_data=0x41, parity_err=0. Then send 0x41 with parity bit 1 -> parity_err=1 with po_flag.
5. STOP_BITS=2: send 0x55 with second stop bit low -> po_flag, po_data=0x55, frame_err=1. Then hold rx low 40 bit-times -> exactly one further po_flag (po_data=0x00, frame_err=1); rise then send 0x12 -> clean reception.
6. Assert rst low for 3 cycles during bit 4 of 0x99 -> all outputs 0 immediately; no po_flag for that frame; the subsequent 0x66 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Parametrised UART receiver with optional parity and 1/2 stop bits
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int HALF         = BAUD_CNT_MAX / 2 - 1;
  localparam int CNT_W        = $clog2(BAUD_CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             ODD_BIT   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_s1;
  logic                 r_s2;
  logic                 r_s3;
  logic [CNT_W-1:0]     r_baud_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop_bad;
  logic                 r_parity_bad;

  logic w_fall;
  logic w_strobe;

  assign w_fall   = ~r_s2 & r_s3;
  assign w_strobe = (r_state != S_IDLE) && (r_baud_cnt == CNT_HALF);

  // Sync flops reset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= rx;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_cnt    <= 4'd0;
      r_shift      <= '0;
      r_stop_bad   <= 1'b0;
      r_parity_bad <= 1'b0;
      po_data      <= '0;
      po_flag      <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      po_flag    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      if (r_state == S_IDLE || r_baud_cnt == CNT_LAST) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            busy    <= 1'b1;
          end
        end

        S_START: begin
          if (w_strobe) begin
            if (r_s2) begin
              r_state    <= S_IDLE;
              busy       <= 1'b0;
              r_baud_cnt <= '0;
            end else begin
              r_state      <= S_DATA;
              r_bit_cnt    <= 4'd0;
              r_stop_bad   <= 1'b0;
              r_parity_bad <= 1'b0;
            end
          end
        end

        S_DATA: begin
          if (w_strobe) begin
            r_shift <= {r_s2, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= 4'd0;
              r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end

        S_PARITY: begin
          if (w_strobe) begin
            r_parity_bad <= (^r_shift) ^ r_s2 ^ ODD_BIT;
            r_bit_cnt    <= 4'd0;
            r_state      <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_strobe) begin
            if (!r_s2) begin
              r_stop_bad <= 1'b1;
            end
            // Finishing at mid-stop leaves half a bit to catch a back-to-back start edge.
            if (r_bit_cnt == STOP_LAST) begin
              r_state    <= S_IDLE;
              busy       <= 1'b0;
              r_baud_cnt <= '0;
              po_flag    <= 1'b1;
              po_data    <= r_shift;
              frame_err  <= r_stop_bad | ~r_s2;
              parity_err <= r_parity_bad;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// ============================================================================
// Module   : tb_uart_rx_cfg
// Brief    : Directed bench for uart_rx_cfg in 8N1, 7E1 and 8N2 configurations
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_cfg;

  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic rx_c = 1'b1;

  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [7:0] data_c;
  logic flag_a, fe_a, pe_a, busy_a;
  logic flag_b, fe_b, pe_b, busy_b;
  logic flag_c, fe_c, pe_c, busy_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int flag_cyc_a = 0;
  int stray = 0;

  // Entries are {frame_err, parity_err, data zero-extended to 9 bits}.
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];
  logic [10:0] q_c[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(160_000), .UART_BPS(10_000), .DATA_BITS(8),
                .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .po_data(data_a), .po_flag(flag_a),
    .frame_err(fe_a), .parity_err(pe_a), .busy(busy_a));

  uart_rx_cfg #(.CLK_FREQ(160_000), .UART_BPS(10_000), .DATA_BITS(7),
                .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .po_data(data_b), .po_flag(flag_b),
    .frame_err(fe_b), .parity_err(pe_b), .busy(busy_b));

  uart_rx_cfg #(.CLK_FREQ(160_000), .UART_BPS(10_000), .DATA_BITS(8),
                .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .rx(rx_c), .po_data(data_c), .po_flag(flag_c),
    .frame_err(fe_c), .parity_err(pe_c), .busy(busy_c));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (flag_a) begin
      q_a.push_back({fe_a, pe_a, 1'b0, data_a});
      flag_cyc_a = cyc;
    end
    if (flag_b) q_b.push_back({fe_b, pe_b, 2'b00, data_b});
    if (flag_c) q_c.push_back({fe_c, pe_c, 1'b0, data_c});
    if ((!flag_a && (fe_a || pe_a)) || (!flag_b && (fe_b || pe_b)) ||
        (!flag_c && (fe_c || pe_c)))
      stray++;
  end

  task automatic drive(input int inst, input logic v, input int n);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int inst, input logic [8:0] d, input int nbits,
                      input int npar, input logic pbit, input logic st1,
                      input logic st2, input int nstop);
    drive(inst, 1'b0, BIT);
    for (int i = 0; i < nbits; i++) drive(inst, d[i], BIT);
    if (npar != 0) drive(inst, pbit, BIT);
    drive(inst, st1, BIT);
    if (nstop == 2) drive(inst, st2, BIT);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({data_a, flag_a, fe_a, pe_a, busy_a} !== 12'h000) begin
      errors++;
      $display("FAIL reset_a: got %h expected 000", {data_a, flag_a, fe_a, pe_a, busy_a});
    end
    checks++;
    if ({data_b, flag_b, fe_b, pe_b, busy_b, data_c, flag_c, fe_c, pe_c, busy_c} !== 23'h0) begin
      errors++;
      $display("FAIL reset_bc: got %h expected 0",
               {data_b, flag_b, fe_b, pe_b, busy_b, data_c, flag_c, fe_c, pe_c, busy_c});
    end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({busy_a, busy_b, busy_c} !== 3'b000 || q_a.size() != 0) begin
      errors++;
      $display("FAIL post_reset_idle: busy %b flags %0d expected 000 / 0",
               {busy_a, busy_b, busy_c}, q_a.size());
    end
  endtask

  task automatic test_single();
    int start;
    q_a.delete();
    start = cyc;
    send(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (q_a.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d expected 1", q_a.size());
    end
    checks++;
    if (q_a[0] !== {2'b00, 9'h0A5}) begin
      errors++;
      $display("FAIL single_data: got %h expected %h", q_a[0], {2'b00, 9'h0A5});
    end
    checks++;
    if (flag_cyc_a - start != 155) begin
      errors++;
      $display("FAIL single_latency: got %0d expected 155", flag_cyc_a - start);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_after: got %b expected 0", busy_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] vals [3];
    vals[0] = 9'h000;
    vals[1] = 9'h0FF;
    vals[2] = 9'h03C;
    q_a.delete();
    for (int i = 0; i < 3; i++) send(0, vals[i], 8, 0, 1'b0, 1'b1, 1'b1, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (q_a.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 3", q_a.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_a[i] !== {2'b00, vals[i]}) begin
        errors++;
        $display("FAIL b2b_data%0d: got %h expected %h", i, q_a[i], {2'b00, vals[i]});
      end
    end
  endtask

  task automatic test_glitch();
    int n;
    n = 0;
    q_a.delete();
    rx_a = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy_a) n++;
    end
    rx_a = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (busy_a) n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL glitch_busy_cycles: got %0d expected 8", n);
    end
    checks++;
    if (q_a.size() != 0 || data_a !== 8'h3C) begin
      errors++;
      $display("FAIL glitch_no_flag: flags %0d data %h expected 0 / 3c", q_a.size(), data_a);
    end
  endtask

  task automatic test_parity();
    q_b.delete();
    send(1, 9'h041, 7, 1, 1'b0, 1'b1, 1'b1, 1);
    repeat (8) @(negedge clk);
    send(1, 9'h041, 7, 1, 1'b1, 1'b1, 1'b1, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (q_b.size() != 2) begin
      errors++;
      $display("FAIL parity_count: got %0d expected 2", q_b.size());
    end
    checks++;
    if (q_b[0] !== {2'b00, 9'h041}) begin
      errors++;
      $display("FAIL parity_good: got %h expected %h", q_b[0], {2'b00, 9'h041});
    end
    checks++;
    if (q_b[1] !== {2'b01, 9'h041}) begin
      errors++;
      $display("FAIL parity_bad: got %h expected %h", q_b[1], {2'b01, 9'h041});
    end
  endtask

  task automatic test_break();
    q_c.delete();
    send(2, 9'h055, 8, 0, 1'b0, 1'b1, 1'b0, 2);
    drive(2, 1'b1, 32);
    checks++;
    if (q_c.size() != 1 || q_c[0] !== {2'b10, 9'h055}) begin
      errors++;
      $display("FAIL stop2_low: count %0d got %h expected 1 / %h", q_c.size(), q_c[0], {2'b10, 9'h055});
    end
    drive(2, 1'b0, 40 * BIT);
    drive(2, 1'b1, 32);
    checks++;
    if (q_c.size() != 2 || q_c[1] !== {2'b10, 9'h000}) begin
      errors++;
      $display("FAIL break_frame: count %0d got %h expected 2 / %h", q_c.size(), q_c[1], {2'b10, 9'h000});
    end
    send(2, 9'h012, 8, 0, 1'b0, 1'b1, 1'b1, 2);
    repeat (8) @(negedge clk);
    checks++;
    if (q_c.size() != 3 || q_c[2] !== {2'b00, 9'h012}) begin
      errors++;
      $display("FAIL after_break: count %0d got %h expected 3 / %h", q_c.size(), q_c[2], {2'b00, 9'h012});
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] d;
    d = 9'h099;
    q_a.delete();
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(0, d[i], BIT);
    drive(0, d[4], BIT / 2);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: got %b expected 1", busy_a);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({data_a, flag_a, fe_a, pe_a, busy_a} !== 12'h000) begin
      errors++;
      $display("FAIL midframe_reset_outputs: got %h expected 000", {data_a, flag_a, fe_a, pe_a, busy_a});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 200);
    checks++;
    if (q_a.size() != 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL aborted_frame: flags %0d busy %b expected 0 / 0", q_a.size(), busy_a);
    end
    send(0, 9'h066, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (q_a.size() != 1 || q_a[0] !== {2'b00, 9'h066}) begin
      errors++;
      $display("FAIL after_reset_frame: count %0d got %h expected 1 / %h", q_a.size(), q_a[0], {2'b00, 9'h066});
    end
  endtask

  task automatic test_stray_errors();
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL error_without_flag: got %0d cycles expected 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_parity();
    test_break();
    test_reset_mid();
    test_stray_errors();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
